// File: rtl/led_seq_ctrl.sv
// Command-driven LED pattern sequencer: BLINK / CHASE / BOUNCE stepped by a 2^DIV_W prescaler.
// Optional LED_HOLD_EN: keep the last displayed pattern after normal completion.
module led_seq_ctrl #(
  parameter int unsigned N_LEDS = 4,
  parameter int unsigned DIV_W  = 10,
  parameter int unsigned REP_W  = 4
) (
  input  logic              clk_in1,
  input  logic              rst_in1,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [1:0]        cmd_mode_in,
  input  logic [REP_W-1:0]  cmd_reps_in,
  input  logic              abort_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [N_LEDS-1:0] led_out
);

  // Largest step index is 2*(N_LEDS-1)-1 (BOUNCE).
  localparam int unsigned STEP_W = $clog2(2 * N_LEDS);

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [1:0] {ModeOff, ModeBlink, ModeChase, ModeBounce} mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [N_LEDS-1:0]  led_q, led_d;
  logic               dir_q, dir_d;  // BOUNCE direction: 0 = left, 1 = right
  logic               done_q, done_d;

  logic               tick;
  logic [STEP_W-1:0]  step_last;
  logic [N_LEDS-1:0]  led_adv;
  logic               dir_adv;

  assign tick          = (div_q == '1);
  assign cmd_ready_out = (state_q == StIdle);
  assign busy_out      = (state_q == StRun);
  assign done_out      = done_q;
  assign led_out       = led_q;

  always_comb begin
    step_last = '0;
    case (mode_q)
      ModeBlink:  step_last = STEP_W'(1);
      ModeChase:  step_last = STEP_W'(N_LEDS - 1);
      ModeBounce: step_last = STEP_W'(2 * N_LEDS - 3);
      default:    step_last = '0;
    endcase
  end

  always_comb begin
    led_adv = led_q;
    dir_adv = dir_q;
    case (mode_q)
      ModeBlink: led_adv = ~led_q;
      ModeChase: led_adv = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
      ModeBounce: begin
        if (!dir_q) begin
          if (led_q[N_LEDS-1]) begin
            led_adv = led_q >> 1;
            dir_adv = 1'b1;
          end else begin
            led_adv = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_adv = led_q << 1;
            dir_adv = 1'b0;
          end else begin
            led_adv = led_q >> 1;
          end
        end
      end
      default: led_adv = led_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    step_d  = step_q;
    rep_d   = rep_q;
    led_d   = led_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_in) begin
          div_d  = '0;
          step_d = '0;
          rep_d  = cmd_reps_in;
          mode_d = mode_e'(cmd_mode_in);
          dir_d  = 1'b0;
          led_d  = (mode_e'(cmd_mode_in) == ModeBlink) ? '1 : N_LEDS'(1);
          if (mode_e'(cmd_mode_in) == ModeOff || cmd_reps_in == '0) begin
            led_d  = '0;
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort_in) begin
          state_d = StIdle;
          led_d   = '0;
          div_d   = '0;
          step_d  = '0;
          rep_d   = '0;
          dir_d   = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
          if (tick) begin
            if (step_q == step_last) begin
              step_d = '0;
              rep_d  = rep_q - REP_W'(1);
              if (rep_q == REP_W'(1)) begin
                // Final step: the last advance is never displayed.
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef LED_HOLD_EN
                led_d   = led_q;
`else
                led_d   = '0;
`endif
              end else begin
                led_d = led_adv;
                dir_d = dir_adv;
              end
            end else begin
              step_d = step_q + STEP_W'(1);
              led_d  = led_adv;
              dir_d  = dir_adv;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (rst_in1) begin
      state_q <= StIdle;
      mode_q  <= ModeOff;
      div_q   <= '0;
      step_q  <= '0;
      rep_q   <= '0;
      led_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with N_LEDS=4, DIV_W=2 (one step every 4 clocks).
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_reps;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] led;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] exp_pats [0:7];

  led_seq_ctrl #(
    .N_LEDS(4),
    .DIV_W (2),
    .REP_W (4)
  ) dut (
    .clk_in1      (clk),
    .rst_in1      (rst),
    .cmd_valid_in (cmd_valid),
    .cmd_ready_out(cmd_ready),
    .cmd_mode_in  (cmd_mode),
    .cmd_reps_in  (cmd_reps),
    .abort_in     (abort),
    .busy_out     (busy),
    .done_out     (done),
    .led_out      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  // Presents a command so it is accepted at the next rising edge (edge E).
  task automatic send(input logic [1:0] mode, input logic [3:0] reps);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_reps  = reps;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Runs one sequence; exp_pats holds the nsteps displayed patterns, 4 cycles each.
  task automatic play(input string tag, input logic [1:0] mode, input logic [3:0] reps,
                      input int nsteps);
    logic [3:0] final_led;
`ifdef LED_HOLD_EN
    final_led = exp_pats[nsteps-1];
`else
    final_led = 4'h0;
`endif
    send(mode, reps);
    for (int k = 0; k < nsteps; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (k == 0 && j == 0) begin
          check({tag, "_busy"}, {31'd0, busy}, 32'd1);
          check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        end
        if (j == 0) check({tag, "_led"}, {28'd0, led}, {28'd0, exp_pats[k]});
        if (k == nsteps - 1 && j == 3) check({tag, "_early_done"}, {31'd0, done}, 32'd0);
      end
    end
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_led_end"}, {28'd0, led}, {28'd0, final_led});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_reps  = 4'd0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    exp_pats = '{4'hf, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    play("blink", 2'd1, 4'd2, 4);
    exp_pats = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    play("chase", 2'd2, 4'd2, 8);
    exp_pats = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h0, 4'h0};
    play("bounce", 2'd3, 4'd1, 6);

    // Abort at E+6 during CHASE
    send(2'd2, 4'd2);
    repeat (6) @(negedge clk);
    check("abort_pre_led", {28'd0, led}, 32'h2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_led", {28'd0, led}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("abort_done2", {31'd0, done}, 32'd0);
    exp_pats = '{4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    play("after_abort", 2'd1, 4'd1, 2);

    // Abort coincident with the completing tick
    send(2'd1, 4'd1);
    repeat (8) @(negedge clk);
    check("abort_fin_pre", {28'd0, led}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_fin_done", {31'd0, done}, 32'd0);
    check("abort_fin_busy", {31'd0, busy}, 32'd0);

    // Immediate completion: mode OFF, and zero repeats
    send(2'd0, 4'd5);
    @(negedge clk);
    check("off_done", {31'd0, done}, 32'd1);
    check("off_busy", {31'd0, busy}, 32'd0);
    check("off_led", {28'd0, led}, 32'd0);
    @(negedge clk);
    check("off_pulse", {31'd0, done}, 32'd0);
    send(2'd1, 4'd0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_led", {28'd0, led}, 32'd0);
    check("zero_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("zero_pulse", {31'd0, done}, 32'd0);

    // Command while busy is ignored
    send(2'd2, 4'd1);
    @(negedge clk);
    check("busy_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_reps  = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_ign_led1", {28'd0, led}, 32'h1);
    repeat (3) @(negedge clk);
    check("busy_ign_led4", {28'd0, led}, 32'h2);
    repeat (12) @(negedge clk);
    check("busy_ign_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("busy_ign_idle", {31'd0, busy}, 32'd0);

    // Valid and abort together in IDLE: command wins
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_reps  = 4'd1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    check("va_busy", {31'd0, busy}, 32'd1);
    check("va_led", {28'd0, led}, 32'hf);
    repeat (8) @(negedge clk);
    check("va_done", {31'd0, done}, 32'd1);

    // Reset mid-run
    send(2'd3, 4'd2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_led", {28'd0, led}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_done", {31'd0, done}, 32'd0);

    // Completion display (held pattern only with LED_HOLD_EN), then reset clears
    exp_pats = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    play("hold", 2'd2, 4'd1, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hold_rst_led", {28'd0, led}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Command-driven sequencer for a bank of blinking LEDs. Accepts a mode/repeat command over a valid/ready handshake, derives a step tick from an internal power-of-two prescaler, and steps the LED pattern. It completes with a done pulse, or stops early on abort. It sits between control logic (buttons, CPU register, test FSM) and the board LED pins, replacing free-running per-LED blinkers.

Parameters:
N_LEDS, 4, number of LED outputs; must be >= 2.
DIV_W, 10, prescaler width; one step tick every 2^DIV_W clocks.
REP_W, 4, width of the repeat count.

Ports:
clk_in1  input  1  system clock; all logic on rising edge.
rst_in1  input  1  synchronous, active-high reset.
cmd_valid_in  input  1  command present.
cmd_ready_out  output  1  high when a command can be accepted (state IDLE).
cmd_mode_in  input  2  0=OFF, 1=BLINK, 2=CHASE, 3=BOUNCE.
cmd_reps_in  input  REP_W  number of pattern repetitions.
abort_in  input  1  stop the running sequence.
busy_out  output  1  high in state RUN.
done_out  output  1  one-cycle pulse on normal completion.
led_out  output  N_LEDS  LED drive, bit 0 = rightmost LED.

Behaviour:
- Reset: state=IDLE, led_out=0, done_out=0, busy_out=0, cmd_ready_out=1; prescaler, step and rep counters cleared.
- States: IDLE and RUN. cmd_ready_out=(state==IDLE); busy_out=(state==RUN).
- Accept: cmd_valid_in & cmd_ready_out sampled at edge E. At E:
  - prescaler=0, step=0, rep=cmd_reps_in.
  - Mode 1 loads led_out=all ones; modes 2/3 load led_out=1 (one-hot bit 0) and set BOUNCE direction to left.
  - Mode 0, or cmd_reps_in==0: stay in IDLE, led_out=0, done_out=1 for the cycle after E.
  - Otherwise: go to RUN.
- Prescaler: DIV_W-bit counter, increments every cycle in RUN, wraps naturally. tick=1 in the cycle where it equals 2^DIV_W-1.
- Steps per repetition (S): BLINK 2; CHASE N_LEDS; BOUNCE 2*(N_LEDS-1).
- On each tick in RUN, led_out advances:
  - BLINK: bitwise invert.
  - CHASE: rotate left by one; MSB wraps to bit 0.
  - BOUNCE: shift left until MSB is set, then shift right until bit 0 is set, then left again.
- Counter update on tick:
  - If step==S-1: step=0 and rep=rep-1; otherwise step=step+1.
  - If step==S-1 and rep==1 (final step): go to IDLE, led_out=0, done_out=1 for exactly one cycle. The final pattern advance is not shown.
- Total RUN length: reps*S*2^DIV_W cycles from E to the completing edge.
- abort_in in RUN: at the next edge go to IDLE, led_out=0, counters cleared, no done_out. abort_in beats a coincident completing tick, so no done_out is issued. abort_in in IDLE is ignored.
- cmd_valid_in during RUN is ignored and not queued; cmd_ready_out=0.
- Reset mid-RUN returns all state to reset values at that edge.
- cmd_valid_in and abort_in high together in IDLE: the command is accepted and the abort is ignored.
- A new command is accepted in the same cycle done_out is high, since state is IDLE.

Optional Feature:
LED_HOLD_EN:
- Defined: on normal completion led_out holds the last displayed pattern (not cleared) until the next accepted command or reset. Abort and reset still clear led_out.
- Undefined: led_out clears to 0 on completion, as specified above.

Test Plan:
- Reset, then hold idle → led_out=0, cmd_ready_out=1, busy_out=0, done_out=0.
- DIV_W=2, N_LEDS=4, BLINK reps=2 accepted at E → led_out=1111 for E..E+4, 0000 for E+4..E+8, 1111 for E+8..E+12, 0000 for E+12..E+16; at E+16 IDLE, led_out=0, done_out=1 for one cycle.
- DIV_W=2, CHASE reps=2 → 0001,0010,0100,1000,0001,0010,0100,1000 (4 cycles each), then done at E+32; BOUNCE reps=1 → 0001,0010,0100,1000,0100,0010, then done at E+24.
- Abort at E+6 during CHASE → next edge: led_out=0, busy_out=0, no done_out; next command accepted normally. Also abort coincident with the final tick → no done_out.
- Mode 0 with reps=5, and BLINK with reps=0 → each stays in IDLE, done_out pulses one cycle, led_out=0. A command issued while busy → cmd_ready_out=0 and it is ignored.
- With LED_HOLD_EN defined, CHASE reps=1 → after done, led_out=1000 held; reset → 0.
